// File: rtl/picoctrl_sequencer.sv
// PicoCtrl fetch/execute core: two-stage pipeline over a combinational 16-bit instruction ROM.
// Optional instruction trace outputs are enabled with `define PICOCTRL_TRACE_EN.
module picoctrl_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic [7:0]        cond_in,
    output logic [7:0]        reg0_out,
    output logic [7:0]        reg1_out,
    output logic [7:0]        reg2_out,
    output logic [7:0]        reg3_out,
    output logic [ADDR_W-1:0] exec_pc
`ifdef PICOCTRL_TRACE_EN
    ,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_pc,
    output logic [15:0]       trace_instr,
    output logic              trace_taken
`endif
);

    typedef enum logic [1:0] {
        ACT_NOP   = 2'b00,
        ACT_WRITE = 2'b01,
        ACT_JUMP  = 2'b10,
        ACT_ADD   = 2'b11
    } action_e;

    typedef struct packed {
        logic [2:0] sel;
        logic       val;
        action_e    act;
        logic [1:0] ridx;
        logic [7:0] imm;
    } instr_t;

    logic [7:0]        sync_q [SYNC_STAGES];
    logic [7:0]        cond_sync;

    logic [ADDR_W-1:0] pc_q, pc_d;
    instr_t            ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic [7:0]        regs_q [4];
    logic [7:0]        regs_d [4];

    logic              cond_true;
    logic              jump_taken;

    // Condition synchronizer keeps sampling regardless of run.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= cond_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign cond_sync = sync_q[SYNC_STAGES-1];
    assign cond_true = (cond_sync[ir_q.sel] == ir_q.val);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        regs_d     = regs_q;
        jump_taken = 1'b0;

        if (run) begin
            if (ir_valid_q && cond_true) begin
                case (ir_q.act)
                    ACT_WRITE: regs_d[ir_q.ridx] = ir_q.imm;
                    ACT_ADD:   regs_d[ir_q.ridx] = regs_q[ir_q.ridx] + ir_q.imm;
                    ACT_JUMP:  jump_taken = 1'b1;
                    default:   ;
                endcase
            end

            // The word fetched alongside a taken jump is loaded but marked invalid: one bubble.
            ir_d       = instr_t'(rom_data);
            ir_pc_d    = pc_q;
            ir_valid_d = !jump_taken;
            pc_d       = jump_taken ? ir_q.imm[ADDR_W-1:0] : pc_q + ADDR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            // NOTE: the register file is tiny and architecturally visible, so it is reset explicitly.
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign rom_addr = pc_q;
    assign exec_pc  = ir_pc_q;
    assign reg0_out = regs_q[0];
    assign reg1_out = regs_q[1];
    assign reg2_out = regs_q[2];
    assign reg3_out = regs_q[3];

`ifdef PICOCTRL_TRACE_EN
    logic              trace_valid_q;
    logic [ADDR_W-1:0] trace_pc_q;
    logic [15:0]       trace_instr_q;
    logic              trace_taken_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            trace_valid_q <= 1'b0;
            trace_pc_q    <= '0;
            trace_instr_q <= '0;
            trace_taken_q <= 1'b0;
        end else begin
            trace_valid_q <= run && ir_valid_q;
            if (run && ir_valid_q) begin
                trace_pc_q    <= ir_pc_q;
                trace_instr_q <= ir_q;
                trace_taken_q <= cond_true;
            end
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_pc    = trace_pc_q;
    assign trace_instr = trace_instr_q;
    assign trace_taken = trace_taken_q;
`endif

endmodule

// File: tb/tb_picoctrl_sequencer.sv
// Scoreboard bench for picoctrl_sequencer: directed programs plus random programs,
// random condition inputs, run pauses and resets, checked against an architectural model.
module tb_picoctrl_sequencer;

    localparam int ADDR_W = 5;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              run;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [7:0]        cond_in;
    logic [7:0]        reg0_out, reg1_out, reg2_out, reg3_out;
    logic [ADDR_W-1:0] exec_pc;
`ifdef PICOCTRL_TRACE_EN
    logic              trace_valid;
    logic [ADDR_W-1:0] trace_pc;
    logic [15:0]       trace_instr;
    logic              trace_taken;
`endif

    logic [15:0] rom [DEPTH];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    picoctrl_sequencer #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .cond_in  (cond_in),
        .reg0_out (reg0_out),
        .reg1_out (reg1_out),
        .reg2_out (reg2_out),
        .reg3_out (reg3_out),
        .exec_pc  (exec_pc)
`ifdef PICOCTRL_TRACE_EN
        ,
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_instr (trace_instr),
        .trace_taken (trace_taken)
`endif
    );

    typedef struct {
        int          pc;
        int          epc;
        bit          chk_epc;
        logic [7:0]  regs [4];
        bit          tv;
        int          tpc;
        logic [15:0] tinstr;
        bit          ttaken;
    } exp_t;

    exp_t exp_q [$];
    int   total = 0;
    int   bad   = 0;

    // Architectural model: program counter, the one fetched-but-not-executed word,
    // the register file and a history of sampled condition inputs.
    int          m_pc;
    bit          m_valid;
    logic [15:0] m_ir;
    int          m_ipc;
    logic [7:0]  m_regs [4];
    logic [7:0]  m_hist [SYNC];

    function automatic logic [15:0] mk(input int s, input int v, input int a, input int r, input int imm);
        logic [15:0] w;
        w = {3'(s), 1'(v), 2'(a), 2'(r), 8'(imm)};
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_step();
        exp_t        e;
        logic [7:0]  cs;
        bit          ok;
        bit          jump;
        int          target;
        int          r;
        e.tv = 0; e.tpc = 0; e.tinstr = '0; e.ttaken = 0;
        if (!reset_n) begin
            m_pc = 0; m_valid = 0; m_ir = '0; m_ipc = 0;
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            for (int i = 0; i < SYNC; i++) m_hist[i] = 8'h00;
        end else begin
            cs     = m_hist[SYNC-1];
            ok     = (cs[m_ir[15:13]] == m_ir[12]);
            jump   = 0;
            target = int'(m_ir[7:0]) % DEPTH;
            r      = int'(m_ir[9:8]);
            if (run && m_valid) begin
                e.tv = 1; e.tpc = m_ipc; e.tinstr = m_ir; e.ttaken = ok;
                if (ok) begin
                    case (m_ir[11:10])
                        2'b01: m_regs[r] = m_ir[7:0];
                        2'b10: jump = 1;
                        2'b11: m_regs[r] = 8'((int'(m_regs[r]) + int'(m_ir[7:0])) % 256);
                        default: ;
                    endcase
                end
            end
            if (run) begin
                m_ir    = rom[m_pc];
                m_ipc   = m_pc;
                m_valid = !jump;
                m_pc    = jump ? target : (m_pc + 1) % DEPTH;
            end
            for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = cond_in;
        end
        e.pc      = m_pc;
        e.epc     = m_ipc;
        e.chk_epc = m_valid || !reset_n;
        for (int i = 0; i < 4; i++) e.regs[i] = m_regs[i];
        exp_q.push_back(e);
    endtask

    task automatic tick(input bit rn, input bit rr, input logic [7:0] c);
        @(negedge clk);
        reset_n = rn;
        run     = rr;
        cond_in = c & 8'hFE;   // c0 is tied low at board level
        @(posedge clk);
        model_step();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b1, 8'h00);
        tick(1'b0, 1'b1, 8'h00);
    endtask

    // Monitor: one expected snapshot per clock edge, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("rom_addr", 32'(rom_addr), 32'(e.pc));
            if (e.chk_epc) check("exec_pc", 32'(exec_pc), 32'(e.epc));
            check("reg0", 32'(reg0_out), 32'(e.regs[0]));
            check("reg1", 32'(reg1_out), 32'(e.regs[1]));
            check("reg2", 32'(reg2_out), 32'(e.regs[2]));
            check("reg3", 32'(reg3_out), 32'(e.regs[3]));
`ifdef PICOCTRL_TRACE_EN
            check("trace_valid", 32'(trace_valid), 32'(e.tv));
            if (e.tv) begin
                check("trace_pc", 32'(trace_pc), 32'(e.tpc));
                check("trace_instr", 32'(trace_instr), 32'(e.tinstr));
                check("trace_taken", 32'(trace_taken), 32'(e.ttaken));
            end
`endif
        end
    end

    initial begin
        logic [7:0] c;
        reset_n = 1'b0;
        run     = 1'b1;
        cond_in = 8'h00;
        clear_rom();

        // Write then tight self-jump, with a 5-cycle run pause in the middle.
        rom[0] = mk(0, 0, 1, 0, 8'h01);
        rom[1] = mk(0, 0, 2, 0, 8'h01);
        do_reset();
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 8'h00);

        // Wait loop on c1 == 1, then release.
        clear_rom();
        rom[0] = mk(0, 0, 1, 0, 8'h01);
        rom[1] = mk(1, 1, 2, 0, 8'h01);
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 8'h02);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 8'h00);

        // Add wrapping modulo 256.
        clear_rom();
        rom[0] = mk(0, 0, 1, 2, 8'h20);
        rom[1] = mk(0, 0, 3, 2, 8'hF0);
        rom[2] = mk(0, 0, 3, 2, 8'hF0);
        do_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 8'h00);

        // All nops: pc wraps 31 -> 0 with no bubbles.
        clear_rom();
        do_reset();
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b1, 8'h00);

        // Reset in mid-flight with reg3 = 0xAA and pc = 0x0C.
        rom[0] = mk(0, 0, 1, 3, 8'hAA);
        do_reset();
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 8'h00);
        tick(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 8'h00);

        // Random programs with random conditions, run pauses and occasional resets.
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < DEPTH; i++)
                rom[i] = mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 255));
            do_reset();
            c = 8'($urandom_range(0, 255));
            for (int n = 0; n < 200; n++) begin
                if ($urandom_range(0, 7) == 0) c = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 39) == 0) begin
                    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, c);
                end else if ($urandom_range(0, 149) == 0) begin
                    tick(1'b0, $urandom_range(0, 1) == 1, c);
                end else begin
                    tick(1'b1, 1'b1, c);
                end
            end
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/picoctrl_sequencer.md
Name: picoctrl_sequencer

Overview:
- Fetch/execute core for the PicoCtrl 16-bit instruction ROMs.
- Drives the ROM address, registers the returned instruction, evaluates its condition against synchronized external condition inputs, and updates four 8-bit output registers or the program counter.
- Sits between a combinational instruction ROM (5-bit address, 16-bit data) and board I/O (switches in, LEDs out).

Parameters:
- ADDR_W, 5, program counter / ROM address width; PC wraps modulo 2^ADDR_W.
- SYNC_STAGES, 2, flip-flop stages on each cond_in bit (legal values 1..3).

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous active-low reset
- run  input  1  1 = advance pipeline; 0 = freeze all state (PC, IR, regs)
- rom_addr  output  ADDR_W  instruction address = PC (direct from PC register)
- rom_data  input  16  instruction word, combinational from ROM, valid same cycle
- cond_in  input  8  asynchronous condition bits c0..c7
- reg0_out, reg1_out, reg2_out, reg3_out  output  8 each  output registers
- exec_pc  output  ADDR_W  address of the instruction currently in execute

Behaviour:
- Instruction format: [15:13] cond bit select s; [12] expected value v; [11:10] action; [9:8] reg index r; [7:0] imm.
- Condition true when cond_sync[s] == v. cond_sync is cond_in after SYNC_STAGES flops.
- Condition code 0b0000 (c0 == 0) is the "always" idiom; c0 must be tied low at top level.
- Actions (effective only if condition true, else no-op):
  - 00 nop
  - 01 write: reg[r] <= imm
  - 10 jump: PC <= imm[ADDR_W-1:0]
  - 11 add: reg[r] <= reg[r] + imm, mod 256, no carry flag
- The all-zero word is nop.
- Two-stage pipeline:
  - F: rom_addr = pc; on the edge, ir <= rom_data, ir_pc <= pc, ir_valid <= 1, pc <= pc+1 (wraps 2^ADDR_W-1 -> 0).
  - E: executes ir when ir_valid = 1.
- Taken jump in E:
  - PC <= target.
  - ir_valid <= 0; the fetched-in-flight instruction is discarded.
  - Exactly one bubble; next executed instruction is at target, 2 cycles after the jump executed.
- Untaken jump: no flush; throughput 1 instruction/cycle.
- Jump to self with condition true is the wait-loop idiom: re-executes every 2 cycles until the condition goes false, then falls through to self+1.
- Register write takes effect on the clock edge ending E; visible on regN_out the next cycle.
- Write and add to the same reg never collide (one instruction per E cycle).
- run = 0:
  - No state changes; sync flops keep sampling.
  - On run returning to 1, resumes exactly where stopped; the frozen ir is not re-fetched.
- Reset (reset_n = 0 at edge), including mid-operation:
  - pc = 0, ir = 0, ir_valid = 0, ir_pc = 0, all regs = 0x00, sync flops = 0, exec_pc = 0.
  - First instruction (addr 0) is fetched in the first cycle after reset deasserts and executes in the second.
- Condition latency: a cond_in change is visible to E after SYNC_STAGES cycles (+ sampling).

Optional Feature:
- Macro PICOCTRL_TRACE_EN.
- When defined: adds outputs trace_valid (1), trace_pc (ADDR_W), trace_instr (16), and trace_taken (1).
  - These are registered, one cycle after each E cycle with ir_valid = 1 and run = 1.
  - trace_taken = condition result.
  - All are reset to 0.
- When undefined: these ports and their registers do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset, then ROM {0: write r0 0x01, 1: always jump 1} -> reg0_out = 0x01 on cycle 3 after reset release; exec_pc alternates 1, bubble; pc never exceeds 2.
- Ping-pong ROM (addr 0 writes 0x01, addr 1 waits on c1 == 1), hold cond_in = 0x02 for 10 cycles, then 0x00 -> reg0_out stays 0x01; advances to addr 2 within SYNC_STAGES + 3 cycles of release.
- add r2 0xF0 twice from 0x20 -> reg2_out = 0x10, then 0x00 (mod 256 wrap).
- ROM of nops, 40 cycles -> pc wraps 31 -> 0; regs unchanged at 0x00; no bubbles.
- Drop run for 5 cycles mid-program, then raise -> pc, regs, and exec_pc frozen; execution sequence identical to the uninterrupted run, shifted by 5 cycles.
- reset_n low for 1 cycle while reg3 = 0xAA and pc = 0x0C -> all regs 0x00, pc 0; with PICOCTRL_TRACE_EN, trace_valid = 0 the next cycle.
